// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate-model BIST: feedback mask, FSM states and
// the Galois LFSR / MISR step functions used by the driver and its compactor.
package gate_bist_pkg;

  localparam int unsigned SIG_W        = 16;
  localparam int unsigned SETTLE_W     = 4;
  localparam logic [15:0] POLY_DEFAULT = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l, input logic [15:0] poly);
    lfsr_step = (l >> 1) ^ (l[0] ? poly : 16'h0000);
  endfunction

  // MISR is the same Galois shift with the response folded in afterwards
  function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [15:0] r,
                                            input logic [15:0] poly);
    misr_step = lfsr_step(m, poly) ^ r;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register compacting the netlist response.
// sig_next_c exposes the value the register would take on a capture edge.
module bist_misr
  import gate_bist_pkg::*;
#(
  parameter int unsigned N_OUT = 10,
  parameter logic [15:0] POLY  = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [N_OUT-1:0] resp,
  output logic [15:0]      signature,
  output logic [15:0]      sig_next_c
);

  logic [15:0] r_sig;

  assign sig_next_c = misr_step(r_sig, 16'(resp), POLY);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= sig_next_c;
    end
  end

  assign signature = r_sig;

endmodule

// File: rtl/gate_model_bist.sv
// BIST driver for a GateModel netlist: applies LFSR patterns on stim, holds each
// for SETTLE_CYCLES+1 cycles, compacts resp into a MISR and grades the signature.
module gate_model_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned N_IN          = 16,
  parameter int unsigned N_OUT         = 10,
  parameter int unsigned PATTERN_COUNT = 1024,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] POLY          = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_IN-1:0]  seed,
  input  logic [15:0]      expected_sig,
  output logic [N_IN-1:0]  stim,
  input  logic [N_OUT-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [15:0]      pattern_idx
);

  state_e              r_state,  w_state_nxt;
  logic [N_IN-1:0]     r_stim,   w_stim_nxt;
  logic [15:0]         r_idx,    w_idx_nxt;
  logic [SETTLE_W-1:0] r_settle, w_settle_nxt;
  logic                r_busy,   w_busy_nxt;
  logic                r_done,   w_done_nxt;
  logic                r_pass,   w_pass_nxt;
  logic                w_misr_clr, w_misr_en;
  logic                w_cap, w_last;
  logic [15:0]         w_sig_nxt;
  logic [N_IN-1:0]     w_seed;

  // An all-zero seed would lock the LFSR, so it is promoted to 1
  assign w_seed = (seed == '0) ? N_IN'(1) : seed;
  assign w_cap  = (r_state == APPLY) && (r_settle == SETTLE_W'(SETTLE_CYCLES));
  assign w_last = (r_idx == 16'(PATTERN_COUNT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_stim   <= '0;
      r_idx    <= '0;
      r_settle <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_stim   <= w_stim_nxt;
      r_idx    <= w_idx_nxt;
      r_settle <= w_settle_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_pass   <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_stim_nxt   = r_stim;
    w_idx_nxt    = r_idx;
    w_settle_nxt = r_settle;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_pass_nxt   = r_pass;
    w_misr_clr   = 1'b0;
    w_misr_en    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt  = APPLY;
          w_stim_nxt   = w_seed;
          w_idx_nxt    = '0;
          w_settle_nxt = '0;
          w_busy_nxt   = 1'b1;
          w_done_nxt   = 1'b0;
          w_pass_nxt   = 1'b0;
          w_misr_clr   = 1'b1;
        end
      end
      APPLY: begin
        if (w_cap) begin
          w_misr_en = 1'b1;
          // Final capture leaves stim and pattern_idx on the last pattern
          if (w_last) begin
            w_state_nxt = DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_sig_nxt == expected_sig);
          end else begin
            w_stim_nxt   = N_IN'(lfsr_step(16'(r_stim), POLY));
            w_idx_nxt    = r_idx + 16'd1;
            w_settle_nxt = '0;
          end
        end else begin
          w_settle_nxt = r_settle + SETTLE_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  bist_misr #(
    .N_OUT (N_OUT),
    .POLY  (POLY)
  ) u_misr (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_misr_clr),
    .en         (w_misr_en),
    .resp       (resp),
    .signature  (signature),
    .sig_next_c (w_sig_nxt)
  );

  assign stim        = r_stim;
  assign pattern_idx = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;

endmodule
